// File: rtl/oppm_decoder.sv
// oppm_decoder: receive-side OPPM decoder.
// Turns the sampled photodiode pulse stream into N_PKT-bit packets, one
// LOG2_M-bit symbol per SYM_CLKS-cycle window, and holds each packet on
// data_DEC/avail_DEC until the player consumes it.
// Optional feature: define OPPM_ERR_CNT_EN to add the saturating err_count
// output (number of error_DEC pulses since reset).
//
// Handshake: avail_DEC is the valid and read_DEC is the ready. A packet
// transfers in any cycle where both are high. avail_DEC then drops on the
// next cycle. data_DEC is stable for the whole time avail_DEC is high.
// read_DEC has no effect while avail_DEC is low.
module oppm_decoder #(
    parameter int N_PKT     = 48,
    parameter int LOG2_M    = 4,
    parameter int SLOT_CLKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    output logic [N_PKT-1:0] data_DEC,
    output logic             avail_DEC,
    output logic             error_DEC,
`ifdef OPPM_ERR_CNT_EN
    output logic [7:0]       err_count,
`endif
    input  logic             read_DEC
);

    localparam int M     = 1 << LOG2_M;
    localparam int N_SYM = N_PKT / LOG2_M;
    localparam int SUB_W = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
    localparam int SYM_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;

    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SLOT_CLKS - 1);
    localparam logic [LOG2_M-1:0] SLOT_LAST = LOG2_M'(M - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(N_SYM - 1);

    if ((N_PKT % LOG2_M) != 0) begin : g_bad_n_pkt
        $error("oppm_decoder: N_PKT must be a multiple of LOG2_M");
    end
    if (SLOT_CLKS < 2) begin : g_bad_slot_clks
        $error("oppm_decoder: SLOT_CLKS must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GUARD = 3'd1,
        SYM   = 3'd2,
        ERR   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic s1, s2, s3;
    logic pulse_edge;

    logic [SUB_W-1:0]  sub;
    logic [LOG2_M-1:0] slot;
    logic [SYM_W-1:0]  sym_idx;
    logic              got;
    logic [LOG2_M-1:0] value;
    logic [N_PKT-1:0]  pkt;

    logic              win_last;
    logic              sym_last;
    logic [LOG2_M-1:0] cur_val;
    logic [N_PKT-1:0]  pkt_next;

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pulse_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse_edge = s2 & ~s3;

    // Window bookkeeping; an edge in the final cycle of a window is its own value.
    always_comb begin
        win_last = (slot == SLOT_LAST) && (sub == SUB_LAST);
        sym_last = (sym_idx == SYM_LAST);
        cur_val  = got ? value : slot;
        pkt_next = (pkt << LOG2_M) | N_PKT'(cur_val);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: framing checks and the hold/consume handshake.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pulse_edge) next_state = GUARD;
            end
            GUARD: begin
                if (pulse_edge)    next_state = ERR;
                else if (win_last) next_state = SYM;
            end
            SYM: begin
                if (pulse_edge && got)                    next_state = ERR;
                else if (win_last && !got && !pulse_edge) next_state = ERR;
                else if (win_last && sym_last)            next_state = HOLD;
            end
            ERR: begin
                next_state = IDLE;
            end
            HOLD: begin
                if (read_DEC) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Moore outputs: the two flags come from disjoint states, so they never overlap.
    always_comb begin
        avail_DEC = (state == HOLD);
        error_DEC = (state == ERR);
    end

    // Slot timing and symbol capture; the preamble clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub     <= '0;
            slot    <= '0;
            sym_idx <= '0;
            got     <= 1'b0;
            value   <= '0;
            pkt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_edge) begin
                        // The preamble cycle is offset 0, so the next cycle is offset 1.
                        sub     <= SUB_W'(1);
                        slot    <= '0;
                        sym_idx <= '0;
                        got     <= 1'b0;
                        value   <= '0;
                        pkt     <= '0;
                    end
                end
                GUARD, SYM: begin
                    if (sub == SUB_LAST) begin
                        sub  <= '0;
                        slot <= slot + 1'b1;
                    end else begin
                        sub <= sub + 1'b1;
                    end
                    if (state == SYM) begin
                        if (win_last) begin
                            got     <= 1'b0;
                            pkt     <= pkt_next;
                            sym_idx <= sym_idx + 1'b1;
                        end else if (pulse_edge && !got) begin
                            got   <= 1'b1;
                            value <= slot;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output packet register: loaded only when a complete frame enters HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_DEC <= '0;
        end else if ((state == SYM) && (next_state == HOLD)) begin
            data_DEC <= pkt_next;
        end
    end

`ifdef OPPM_ERR_CNT_EN
    // Saturating count of error pulses, bumped during the ERR cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if ((state == ERR) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oppm_decoder.sv
// tb_oppm_decoder: directed bench for oppm_decoder (default parameters).
// Each play() step drives pulse_in/read_DEC from per-cycle schedules and
// records the outputs 1 ns after the rising clock edge. A level placed at
// schedule index a shows up as an edge in recorded cycle a+1, so a preamble
// at index a gives E0 = a+1. read_DEC at index i is consumed at that clock,
// so its effect is visible in recorded cycle i.
module tb_oppm_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pulse_in;
    logic        read_DEC;
    logic [47:0] data_DEC;
    logic        avail_DEC;
    logic        error_DEC;
`ifdef OPPM_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam int HMAX = 1200;
    logic        p_s[HMAX];
    logic        r_s[HMAX];
    logic        h_avail[HMAX];
    logic        h_err[HMAX];
    logic [47:0] h_data[HMAX];

    logic [47:0] last_good;

    oppm_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .data_DEC  (data_DEC),
        .avail_DEC (avail_DEC),
        .error_DEC (error_DEC),
`ifdef OPPM_ERR_CNT_EN
        .err_count (err_count),
`endif
        .read_DEC  (read_DEC)
    );

    always #5 clk = ~clk;

    task automatic clear_sched();
        for (int i = 0; i < HMAX; i++) begin
            p_s[i] = 1'b0;
            r_s[i] = 1'b0;
        end
    endtask

    // Preamble at index a, then symbols 0..last_sym as 2-clock pulses at offset 4*nibble.
    // skip_sym leaves one window empty; sym0_off >= 0 puts a 1-clock symbol-0 pulse there.
    task automatic add_frame(input int a, input logic [47:0] pkt, input int last_sym,
                             input int skip_sym, input int sym0_off);
        int off;
        p_s[a]     = 1'b1;
        p_s[a + 1] = 1'b1;
        for (int i = 0; i <= last_sym; i++) begin
            if (i == skip_sym) continue;
            if (i == 0 && sym0_off >= 0) begin
                p_s[a + 64 + sym0_off] = 1'b1;
            end else begin
                off = a + (i + 1) * 64 + 4 * int'(pkt[47 - 4 * i -: 4]);
                p_s[off]     = 1'b1;
                p_s[off + 1] = 1'b1;
            end
        end
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in = p_s[i];
            read_DEC = r_s[i];
            @(posedge clk);
            #1;
            h_avail[i] = avail_DEC;
            h_err[i]   = error_DEC;
            h_data[i]  = data_DEC;
        end
        pulse_in = 1'b0;
        read_DEC = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        pulse_in = 1'b0;
        read_DEC = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (data_DEC !== 48'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", data_DEC); end
        n_cmp++;
        if (avail_DEC !== 1'b0) begin n_bad++; $display("FAIL reset_avail got=%b exp=0", avail_DEC); end
        n_cmp++;
        if (error_DEC !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%b exp=0", error_DEC); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_sched();
        play(100);
        for (int j = 0; j < 100; j++) begin
            n_cmp++;
            if (h_data[j] !== 48'h0) begin n_bad++; $display("FAIL idle_data cyc=%0d got=%h exp=0", j, h_data[j]); end
            n_cmp++;
            if (h_avail[j] !== 1'b0) begin n_bad++; $display("FAIL idle_avail cyc=%0d got=%b exp=0", j, h_avail[j]); end
            n_cmp++;
            if (h_err[j] !== 1'b0) begin n_bad++; $display("FAIL idle_error cyc=%0d got=%b exp=0", j, h_err[j]); end
        end
    endtask

    // E0 = 6, so avail_DEC must rise at cycle 6 + 832 = 838.
    task automatic test_frame();
        clear_sched();
        add_frame(5, 48'hA5A5_0F0F_1234, 11, -1, -1);
        play(900);
        for (int j = 0; j < 900; j++) begin
            n_cmp++;
            if (h_avail[j] !== (j >= 838)) begin n_bad++; $display("FAIL frame_avail cyc=%0d got=%b exp=%b", j, h_avail[j], (j >= 838)); end
            n_cmp++;
            if (h_err[j] !== 1'b0) begin n_bad++; $display("FAIL frame_error cyc=%0d got=%b exp=0", j, h_err[j]); end
            if (j >= 838) begin
                n_cmp++;
                if (h_data[j] !== 48'hA5A5_0F0F_1234) begin n_bad++; $display("FAIL frame_data cyc=%0d got=%h exp=a5a50f0f1234", j, h_data[j]); end
            end
        end
        last_good = 48'hA5A5_0F0F_1234;
    endtask

    // Still in HOLD: a second frame is lost; read at 950 (with an edge in the
    // same cycle) returns to IDLE and that edge must not start a frame.
    task automatic test_hold();
        clear_sched();
        add_frame(10, 48'h1234_5678_9ABC, 11, -1, -1);
        p_s[948] = 1'b1;
        r_s[950] = 1'b1;
        play(1100);
        for (int j = 0; j < 1100; j++) begin
            n_cmp++;
            if (h_avail[j] !== (j < 950)) begin n_bad++; $display("FAIL hold_avail cyc=%0d got=%b exp=%b", j, h_avail[j], (j < 950)); end
            n_cmp++;
            if (h_err[j] !== 1'b0) begin n_bad++; $display("FAIL hold_error cyc=%0d got=%b exp=0", j, h_err[j]); end
            n_cmp++;
            if (h_data[j] !== 48'hA5A5_0F0F_1234) begin n_bad++; $display("FAIL hold_data cyc=%0d got=%h exp=a5a50f0f1234", j, h_data[j]); end
        end
    endtask

    // Symbol-0 edges at offsets 3, 4, 63 decode as 0, 1, 15. E0 = 3, rise at 835.
    task automatic test_slot_boundaries();
        int          offs[3];
        logic [3:0]  nibs[3];
        logic [47:0] base;
        logic [47:0] exp_data;
        offs[0] = 3;  nibs[0] = 4'h0;
        offs[1] = 4;  nibs[1] = 4'h1;
        offs[2] = 63; nibs[2] = 4'hF;
        base = 48'h0123_4567_89AB;
        for (int k = 0; k < 3; k++) begin
            exp_data = {nibs[k], base[43:0]};
            clear_sched();
            add_frame(2, base, 11, -1, offs[k]);
            r_s[850] = 1'b1;
            play(860);
            for (int j = 0; j < 860; j++) begin
                n_cmp++;
                if (h_avail[j] !== (j >= 835 && j < 850)) begin n_bad++; $display("FAIL slot%0d_avail cyc=%0d got=%b exp=%b", offs[k], j, h_avail[j], (j >= 835 && j < 850)); end
                n_cmp++;
                if (h_err[j] !== 1'b0) begin n_bad++; $display("FAIL slot%0d_error cyc=%0d got=%b exp=0", offs[k], j, h_err[j]); end
            end
            n_cmp++;
            if (h_data[835] !== exp_data) begin n_bad++; $display("FAIL slot%0d_data got=%h exp=%h", offs[k], h_data[835], exp_data); end
            last_good = exp_data;
        end
    endtask

    // No pulse in window 5: its last cycle is E0+447 = 451, error at 452 only.
    task automatic test_missing_window();
        clear_sched();
        add_frame(3, 48'hA5A5_0F0F_1234, 4, -1, -1);
        play(600);
        for (int j = 0; j < 600; j++) begin
            n_cmp++;
            if (h_err[j] !== (j == 452)) begin n_bad++; $display("FAIL miss_error cyc=%0d got=%b exp=%b", j, h_err[j], (j == 452)); end
            n_cmp++;
            if (h_avail[j] !== 1'b0) begin n_bad++; $display("FAIL miss_avail cyc=%0d got=%b exp=0", j, h_avail[j]); end
            n_cmp++;
            if (h_data[j] !== last_good) begin n_bad++; $display("FAIL miss_data cyc=%0d got=%h exp=%h", j, h_data[j], last_good); end
        end
`ifdef OPPM_ERR_CNT_EN
        n_cmp++;
        if (err_count !== 8'd1) begin n_bad++; $display("FAIL miss_err_count got=%0d exp=1", err_count); end
`endif
    endtask

    // Clean frame after an error: E0 = 4, rise at 836, read at 880.
    task automatic test_recovery();
        clear_sched();
        add_frame(3, 48'h1, 11, -1, -1);
        r_s[880] = 1'b1;
        play(900);
        for (int j = 0; j < 900; j++) begin
            n_cmp++;
            if (h_avail[j] !== (j >= 836 && j < 880)) begin n_bad++; $display("FAIL recov_avail cyc=%0d got=%b exp=%b", j, h_avail[j], (j >= 836 && j < 880)); end
            n_cmp++;
            if (h_err[j] !== 1'b0) begin n_bad++; $display("FAIL recov_error cyc=%0d got=%b exp=0", j, h_err[j]); end
        end
        n_cmp++;
        if (h_data[836] !== 48'h1) begin n_bad++; $display("FAIL recov_data got=%h exp=1", h_data[836]); end
        last_good = 48'h1;
    endtask

    // Second edge in window 2 at E0+242 = 246, error at 247.
    task automatic test_double_edge();
        clear_sched();
        add_frame(3, 48'hA5A5_0F0F_1234, 2, -1, -1);
        p_s[3 + 3 * 64 + 50] = 1'b1;
        play(400);
        for (int j = 0; j < 400; j++) begin
            n_cmp++;
            if (h_err[j] !== (j == 247)) begin n_bad++; $display("FAIL dbl_error cyc=%0d got=%b exp=%b", j, h_err[j], (j == 247)); end
            n_cmp++;
            if (h_avail[j] !== 1'b0) begin n_bad++; $display("FAIL dbl_avail cyc=%0d got=%b exp=0", j, h_avail[j]); end
        end
`ifdef OPPM_ERR_CNT_EN
        n_cmp++;
        if (err_count !== 8'd2) begin n_bad++; $display("FAIL dbl_err_count got=%0d exp=2", err_count); end
`endif
    endtask

    // Edge at E0+10 = 14 inside GUARD, error at 15.
    task automatic test_guard_edge();
        clear_sched();
        p_s[3]  = 1'b1;
        p_s[4]  = 1'b1;
        p_s[13] = 1'b1;
        play(200);
        for (int j = 0; j < 200; j++) begin
            n_cmp++;
            if (h_err[j] !== (j == 15)) begin n_bad++; $display("FAIL guard_error cyc=%0d got=%b exp=%b", j, h_err[j], (j == 15)); end
            n_cmp++;
            if (h_data[j] !== last_good) begin n_bad++; $display("FAIL guard_data cyc=%0d got=%h exp=%h", j, h_data[j], last_good); end
        end
`ifdef OPPM_ERR_CNT_EN
        n_cmp++;
        if (err_count !== 8'd3) begin n_bad++; $display("FAIL guard_err_count got=%0d exp=3", err_count); end
`endif
    endtask

    // Reset asserted mid-frame between clock edges: outputs clear at once, no error afterwards.
    task automatic test_reset_mid_frame();
        clear_sched();
        add_frame(3, 48'hA5A5_0F0F_1234, 11, -1, -1);
        play(300);
        n_cmp++;
        if (data_DEC !== last_good) begin n_bad++; $display("FAIL midrst_pre_data got=%h exp=%h", data_DEC, last_good); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (data_DEC !== 48'h0) begin n_bad++; $display("FAIL midrst_data got=%h exp=0", data_DEC); end
        n_cmp++;
        if (avail_DEC !== 1'b0) begin n_bad++; $display("FAIL midrst_avail got=%b exp=0", avail_DEC); end
        n_cmp++;
        if (error_DEC !== 1'b0) begin n_bad++; $display("FAIL midrst_error got=%b exp=0", error_DEC); end
`ifdef OPPM_ERR_CNT_EN
        n_cmp++;
        if (err_count !== 8'd0) begin n_bad++; $display("FAIL midrst_err_count got=%0d exp=0", err_count); end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_sched();
        play(300);
        for (int j = 0; j < 300; j++) begin
            n_cmp++;
            if (h_err[j] !== 1'b0) begin n_bad++; $display("FAIL postrst_error cyc=%0d got=%b exp=0", j, h_err[j]); end
            n_cmp++;
            if (h_avail[j] !== 1'b0) begin n_bad++; $display("FAIL postrst_avail cyc=%0d got=%b exp=0", j, h_avail[j]); end
            n_cmp++;
            if (h_data[j] !== 48'h0) begin n_bad++; $display("FAIL postrst_data cyc=%0d got=%h exp=0", j, h_data[j]); end
        end
    endtask

    initial begin
        last_good = 48'h0;
        test_reset();
        test_frame();
        test_hold();
        test_slot_boundaries();
        test_missing_window();
        test_recovery();
        test_double_edge();
        test_guard_edge();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Time limit: the directed sequence needs well under 100 us.
    initial begin
        #2_000_000;
        $display("FAIL watchdog sim time exceeded got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
